filter_sequencer: RTL

//  Job-level controller for one pixel-filter instance: accepts a job (mode/omega/epsilon/len), buffers
//  len pixel groups, then bursts them back-to-back into the filter, which advances its round counter

---
 rtl/filter_pkg.sv | 18 +
 rtl/filter_seq_buf.sv | 26 ++
 rtl/filter_sequencer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/filter_pkg.sv
// Shared types for the filter sequencer: FSM state encoding and filter mode codes.
package filter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    RUN,
    CLEAR,
    DRAIN
  } seq_state_t;

  localparam int unsigned MODE_MASK  = 0;
  localparam int unsigned MODE_ROUND = 1;
  localparam int unsigned MODE_PIXEL = 2;
  localparam int unsigned MODE_INDEX = 3;

endpackage

// File: rtl/filter_seq_buf.sv
// Register-array group buffer: one synchronous write port, one asynchronous read port.
module filter_seq_buf #(
  parameter int DEPTH = 8,
  parameter int DW    = 24,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Contents are don't-care after reset; readers gate what they expose.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/filter_sequencer.sv
// Job-level controller for one pixel filter: buffer a job, burst it into the filter, stream results back.
// Optional FILTER_SEQ_STATS_EN adds saturating job and nonzero-result-pixel counters.
module filter_sequencer
  import filter_pkg::*;
#(
  parameter  int PIXEL_SIZE = 3,
  parameter  int PIXEL_NUM  = 3,
  parameter  int DEPTH      = 8,
  localparam int W          = 2**PIXEL_SIZE,
  localparam int LW         = $clog2(DEPTH+1),
  localparam int GW         = W*PIXEL_NUM
) (
  input  logic          clk,
  input  logic          areset,
  input  logic          job_valid,
  output logic          job_ready,
  input  logic [W-1:0]  job_mode,
  input  logic [W-1:0]  job_omega,
  input  logic [W-1:0]  job_epsilon,
  input  logic [LW-1:0] job_len,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [GW-1:0] in_pixel,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [GW-1:0] out_result,
  output logic          out_last,
  output logic          busy,
  output logic [W-1:0]  f_mode,
  output logic [W-1:0]  f_omega,
  output logic [W-1:0]  f_epsilon,
  output logic [GW-1:0] f_pixel,
  input  logic [GW-1:0] f_result,
  output logic          f_enable,
  output logic          f_clear,
  input  logic          f_ready
`ifdef FILTER_SEQ_STATS_EN
  ,
  output logic [15:0]   stat_jobs,
  output logic [15:0]   stat_hits
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  seq_state_t    state, state_next;
  logic [LW-1:0] len_q, loaded, run_cnt, rd, len_clamped;
  logic          in_hs, out_hs, capture;
  logic [AW-1:0] cap_idx;
  logic [GW-1:0] in_rdata, res_rdata;

  assign len_clamped = (job_len > LW'(DEPTH)) ? LW'(DEPTH) : job_len;
  assign in_hs       = in_valid && in_ready;
  assign out_hs      = out_valid && out_ready;
  assign busy        = (state != IDLE);

  // The filter result lags its round by one cycle, so round k lands in slot run_cnt-1
  // during RUN cycles 1..len-1 and in the CLEAR cycle (where run_cnt == len).
  assign cap_idx = run_cnt[AW-1:0] - AW'(1);
  assign capture = (((state == RUN) && (run_cnt != '0)) || (state == CLEAR)) && f_ready;

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state     <= IDLE;
      len_q     <= '0;
      loaded    <= '0;
      run_cnt   <= '0;
      rd        <= '0;
      f_mode    <= '0;
      f_omega   <= '0;
      f_epsilon <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          loaded  <= '0;
          run_cnt <= '0;
          rd      <= '0;
          if (job_valid) begin
            len_q     <= len_clamped;
            f_mode    <= job_mode;
            f_omega   <= job_omega;
            f_epsilon <= job_epsilon;
          end
        end
        LOAD: begin
          if (in_hs) begin
            loaded <= loaded + LW'(1);
          end
        end
        RUN, CLEAR: run_cnt <= run_cnt + LW'(1);
        DRAIN: begin
          if (out_hs) begin
            rd <= rd + LW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // job_ready is gated by reset so every output reads zero while reset is held.
  always_comb begin
    state_next = state;
    job_ready  = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    out_result = '0;
    f_pixel    = '0;
    f_enable   = 1'b0;
    f_clear    = 1'b0;
    case (state)
      IDLE: begin
        job_ready = areset;
        if (job_valid && (len_clamped != '0)) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        in_ready = (loaded < len_q);
        if (in_valid && (loaded == len_q - LW'(1))) begin
          state_next = START;
        end
      end
      START: begin
        f_enable   = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        f_pixel = in_rdata;
        if (run_cnt == len_q - LW'(1)) begin
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        f_clear    = 1'b1;
        state_next = DRAIN;
      end
      DRAIN: begin
        out_valid  = (rd < len_q);
        out_result = out_valid ? res_rdata : '0;
        out_last   = out_valid && (rd == len_q - LW'(1));
        if (out_ready && out_last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  filter_seq_buf #(.DEPTH(DEPTH), .DW(GW), .AW(AW)) u_inbuf (
    .clk   (clk),
    .we    (in_hs),
    .waddr (loaded[AW-1:0]),
    .wdata (in_pixel),
    .raddr (run_cnt[AW-1:0]),
    .rdata (in_rdata)
  );

  filter_seq_buf #(.DEPTH(DEPTH), .DW(GW), .AW(AW)) u_resbuf (
    .clk   (clk),
    .we    (capture),
    .waddr (cap_idx),
    .wdata (f_result),
    .raddr (rd[AW-1:0]),
    .rdata (res_rdata)
  );

`ifdef FILTER_SEQ_STATS_EN
  logic [16:0] hit_sum;

  always_comb begin
    hit_sum = {1'b0, stat_hits};
    if (capture) begin
      for (int i = 0; i < PIXEL_NUM; i++) begin
        if (f_result[i*W +: W] != '0) begin
          hit_sum = hit_sum + 17'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      stat_jobs <= '0;
      stat_hits <= '0;
    end else begin
      if (out_hs && out_last && (stat_jobs != 16'hFFFF)) begin
        stat_jobs <= stat_jobs + 16'd1;
      end
      stat_hits <= hit_sum[16] ? 16'hFFFF : hit_sum[15:0];
    end
  end
`endif

endmodule
